// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and default widths for the data-memory arbiter that sits
// between the CPU data port, the debug/loader port and the single dmem.
//   arb_state_e : arbiter ownership state
//   owner_e     : which port was granted most recently
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    localparam int DEF_AW       = 16;
    localparam int DEF_DW       = 16;
    localparam int DEF_MAX_HOLD = 4;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CPU_OWN    = 2'd1,
        DBG_OWN    = 2'd2,
        DBG_LOCKED = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

endpackage

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one synchronous-read data memory between the CPU data port and a
// debug/loader port. At most one access is issued per cycle; read data comes
// back to the winning port one cycle after its grant. The debug port can lock
// the memory for atomic sequences.
//
// Ports
//   clk, rst                  clock; synchronous active-low reset
//   cpu_req/we/addr/wdata     CPU request (held until granted)
//   dbg_req/we/addr/wdata     debug request (held until granted)
//   dbg_lock                  keep the memory with the debug port
//   cpu_gnt, dbg_gnt          combinational grant, access accepted this cycle
//   cpu_stall                 CPU request pending but not granted
//   cpu_rvalid/rdata          registered read-valid, gated read data
//   dbg_rvalid/rdata          registered read-valid, gated read data
//   mem_en/we/addr/wdata      memory strobe and access, muxed from the winner
//   mem_rdata                 memory read data, valid the cycle after a read
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    input  logic          dbg_lock,
    output logic          cpu_gnt,
    output logic          dbg_gnt,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);

    arb_state_e    state_reg, state_next;
    owner_e        last_owner_reg, last_owner_next;
    logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
    logic          cpu_rvalid_reg, cpu_rvalid_next;
    logic          dbg_rvalid_reg, dbg_rvalid_next;

    // Raw arbitration decision, before reset gating.
    logic          grant_cpu, grant_dbg;
    logic [HW-1:0] hold_inc;

    assign hold_inc = (hold_cnt_reg == HOLD_MAX) ? hold_cnt_reg : hold_cnt_reg + HOLD_ONE;

    always_comb begin
        grant_cpu       = 1'b0;
        grant_dbg       = 1'b0;
        state_next      = state_reg;
        hold_cnt_next   = hold_cnt_reg;
        last_owner_next = last_owner_reg;

        // Who wins this cycle.
        case (state_reg)
            IDLE: begin
                if (cpu_req && dbg_req) begin
                    if (last_owner_reg == OWN_DBG) grant_cpu = 1'b1;
                    else                           grant_dbg = 1'b1;
                end else if (cpu_req) begin
                    grant_cpu = 1'b1;
                end else if (dbg_req) begin
                    grant_dbg = 1'b1;
                end
            end
            CPU_OWN: begin
                if (cpu_req && dbg_req) begin
                    if (hold_cnt_reg < HOLD_MAX) grant_cpu = 1'b1;
                    else                         grant_dbg = 1'b1;
                end else if (cpu_req) begin
                    grant_cpu = 1'b1;
                end else if (dbg_req) begin
                    grant_dbg = 1'b1;
                end
            end
            DBG_OWN: begin
                if (cpu_req && dbg_req) begin
                    if (hold_cnt_reg < HOLD_MAX) grant_dbg = 1'b1;
                    else                         grant_cpu = 1'b1;
                end else if (dbg_req) begin
                    grant_dbg = 1'b1;
                end else if (cpu_req) begin
                    grant_cpu = 1'b1;
                end
            end
            DBG_LOCKED: begin
                // CPU is shut out for the whole locked period, including the
                // cycle in which the lock is released.
                if (dbg_req) grant_dbg = 1'b1;
            end
            default: begin
                grant_cpu = 1'b0;
                grant_dbg = 1'b0;
            end
        endcase

        // Where that decision leaves the state and the hold counter.
        if (state_reg == DBG_LOCKED) begin
            if (dbg_lock) begin
                // Lock survives idle cycles; hold count is meaningless here
                // but kept saturating so DBG_OWN inherits a sane value.
                state_next = DBG_LOCKED;
                if (grant_dbg) hold_cnt_next = hold_inc;
            end else if (grant_dbg) begin
                state_next    = DBG_OWN;
                hold_cnt_next = hold_inc;
            end else begin
                state_next    = IDLE;
                hold_cnt_next = '0;
            end
        end else if (grant_cpu) begin
            state_next    = CPU_OWN;
            hold_cnt_next = (state_reg == CPU_OWN) ? hold_inc : HOLD_ONE;
        end else if (grant_dbg) begin
            state_next    = dbg_lock ? DBG_LOCKED : DBG_OWN;
            hold_cnt_next = (state_reg == DBG_OWN) ? hold_inc : HOLD_ONE;
        end else begin
            state_next    = IDLE;
            hold_cnt_next = '0;
        end

        if (grant_cpu) last_owner_next = OWN_CPU;
        if (grant_dbg) last_owner_next = OWN_DBG;
    end

    // Grants are suppressed while reset is asserted so nothing reaches memory.
    assign cpu_gnt   = rst & grant_cpu;
    assign dbg_gnt   = rst & grant_dbg;
    assign cpu_stall = rst & cpu_req & ~cpu_gnt;

    assign cpu_rvalid_next = cpu_gnt & ~cpu_we;
    assign dbg_rvalid_next = dbg_gnt & ~dbg_we;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            last_owner_reg <= OWN_DBG;
            hold_cnt_reg   <= '0;
            cpu_rvalid_reg <= 1'b0;
            dbg_rvalid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_owner_reg <= last_owner_next;
            hold_cnt_reg   <= hold_cnt_next;
            cpu_rvalid_reg <= cpu_rvalid_next;
            dbg_rvalid_reg <= dbg_rvalid_next;
        end
    end

    // Memory side: plain mux of the winning port, all zero when nobody wins.
    always_comb begin
        mem_en    = cpu_gnt | dbg_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    // rvalid is gated with rst so every output reads 0 while reset is held.
    assign cpu_rvalid = rst & cpu_rvalid_reg;
    assign dbg_rvalid = rst & dbg_rvalid_reg;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
    logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic        cpu_gnt, dbg_gnt, cpu_stall, cpu_rvalid, dbg_rvalid;
    logic [15:0] cpu_rdata, dbg_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    dmem_arbiter #(.AW(16), .DW(16), .MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_lock(dbg_lock),
        .cpu_gnt(cpu_gnt), .dbg_gnt(dbg_gnt), .cpu_stall(cpu_stall),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory the arbiter drives.
    logic [15:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    // Scoreboard reference contents, updated from observed grants.
    logic [15:0] ref_mem [0:255];

    typedef struct {
        int          due;
        logic [15:0] data;
    } exp_t;
    exp_t cpu_q[$];
    exp_t dbg_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // Response checker first, then record this cycle's grants.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            cpu_q.delete();
            dbg_q.delete();
        end else begin
            if (cpu_rvalid) begin
                if (cpu_q.size() == 0) chk("cpu_rv_unexp", 32'(cpu_rvalid), 32'd0);
                else begin
                    e = cpu_q.pop_front();
                    chk("cpu_rv_time", cyc, e.due);
                    chk("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
                    $display("cpu read resp data=%h cycle=%0d", cpu_rdata, cyc);
                end
            end else if (cpu_q.size() > 0 && cpu_q[0].due <= cyc) begin
                chk("cpu_rv_missing", 32'(cpu_rvalid), 32'd1);
                void'(cpu_q.pop_front());
            end
            if (dbg_rvalid) begin
                if (dbg_q.size() == 0) chk("dbg_rv_unexp", 32'(dbg_rvalid), 32'd0);
                else begin
                    e = dbg_q.pop_front();
                    chk("dbg_rv_time", cyc, e.due);
                    chk("dbg_rdata", 32'(dbg_rdata), 32'(e.data));
                    $display("dbg read resp data=%h cycle=%0d", dbg_rdata, cyc);
                end
            end else if (dbg_q.size() > 0 && dbg_q[0].due <= cyc) begin
                chk("dbg_rv_missing", 32'(dbg_rvalid), 32'd1);
                void'(dbg_q.pop_front());
            end
            if (cpu_gnt) begin
                if (cpu_we) ref_mem[cpu_addr[7:0]] = cpu_wdata;
                else cpu_q.push_back('{due: cyc + 1, data: ref_mem[cpu_addr[7:0]]});
            end
            if (dbg_gnt) begin
                if (dbg_we) ref_mem[dbg_addr[7:0]] = dbg_wdata;
                else dbg_q.push_back('{due: cyc + 1, data: ref_mem[dbg_addr[7:0]]});
            end
        end
    end

    task automatic drive_idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_lock = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {25'd0, cpu_gnt, dbg_gnt, cpu_stall, cpu_rvalid, dbg_rvalid, mem_en, mem_we}, 32'd0);
        chk({tag, "_rd"},  {cpu_rdata, dbg_rdata}, 32'd0);
        chk({tag, "_mem"}, {mem_addr, mem_wdata}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 0;
        step();
        @(negedge clk); chk_all_zero("rst");
        step();
        rst = 1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 16'(i * 3 + 1);
            ref_mem[i] = 16'(i * 3 + 1);
        end
        mem[4]     = 16'h1234;
        ref_mem[4] = 16'h1234;
        mem_rdata  = 16'h0;
        rst = 0;
        drive_idle();
        do_reset();

        // Plain CPU read after reset.
        cpu_req = 1; cpu_addr = 16'h0004;
        @(negedge clk);
        chk("t1_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("t1_dbg_gnt", 32'(dbg_gnt), 32'd0);
        chk("t1_mem_en", 32'(mem_en), 32'd1);
        step(); drive_idle();
        @(negedge clk);
        chk("t1_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("t1_cpu_rdata", 32'(cpu_rdata), 32'h1234);
        chk("t1_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
        $display("t1 cpu read addr=0004 done");

        // Both requesting continuously from a fresh reset.
        step(); do_reset();
        cpu_req = 1; cpu_addr = 16'h0004;
        dbg_req = 1; dbg_addr = 16'h0005;
        for (int i = 0; i < 12; i++) begin
            logic exp_cpu;
            exp_cpu = (i < 4) || (i >= 8);
            @(negedge clk);
            chk($sformatf("t2_cpu_gnt_%0d", i), 32'(cpu_gnt), 32'(exp_cpu));
            chk($sformatf("t2_dbg_gnt_%0d", i), 32'(dbg_gnt), 32'(!exp_cpu));
            chk($sformatf("t2_stall_%0d", i), 32'(cpu_stall), 32'(!exp_cpu));
            $display("t2 slot %0d cpu_gnt=%0b dbg_gnt=%0b", i, cpu_gnt, dbg_gnt);
            step();
        end
        drive_idle();
        step();

        // Locked debug sequence against a constantly requesting CPU.
        cpu_req = 1; cpu_addr = 16'h0008;
        dbg_req = 1; dbg_we = 1; dbg_addr = 16'h0010; dbg_wdata = 16'h00AA; dbg_lock = 1;
        @(negedge clk);
        chk("t3_dbg_wr_gnt", 32'(dbg_gnt), 32'd1);
        chk("t3_stall_0", 32'(cpu_stall), 32'd1);
        chk("t3_mem_we", {15'd0, mem_we, mem_addr}, {15'd0, 1'b1, 16'h0010});
        step();
        dbg_req = 0; dbg_we = 0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk($sformatf("t3_stall_%0d", i), 32'(cpu_stall), 32'd1);
            chk($sformatf("t3_gnt_%0d", i), {30'd0, cpu_gnt, dbg_gnt}, 32'd0);
            step();
        end
        dbg_req = 1; dbg_addr = 16'h0010;
        @(negedge clk);
        chk("t3_dbg_rd_gnt", 32'(dbg_gnt), 32'd1);
        chk("t3_stall_4", 32'(cpu_stall), 32'd1);
        step();
        dbg_req = 0; dbg_lock = 0;
        @(negedge clk);
        chk("t3_dbg_rdata", 32'(dbg_rdata), 32'h00AA);
        chk("t3_cpu_gnt_unlock", 32'(cpu_gnt), 32'd0);
        $display("t3 locked write/read addr=0010 done");
        step();

        // CPU alone for 10 cycles, then debug joins.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("t4_cpu_gnt_%0d", i), 32'(cpu_gnt), 32'd1);
            step();
        end
        dbg_req = 1; dbg_addr = 16'h0011;
        @(negedge clk);
        chk("t4_dbg_gnt", 32'(dbg_gnt), 32'd1);
        chk("t4_cpu_gnt", 32'(cpu_gnt), 32'd0);
        $display("t4 cpu solo run then debug takeover done");
        step(); drive_idle();
        step();

        // Read requested while reset is held.
        rst = 0; cpu_req = 1; cpu_addr = 16'h0004;
        @(negedge clk);
        chk_all_zero("t5_in_rst");
        step(); rst = 1; drive_idle();
        @(negedge clk);
        chk("t5_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("t5_cpu_rdata", 32'(cpu_rdata), 32'd0);
        $display("t5 read during reset dropped");
        step();

        // CPU write, then read it back.
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0000; cpu_wdata = 16'h0007;
        @(negedge clk);
        chk("t6_mem_en_we", {30'd0, mem_en, mem_we}, 32'd3);
        chk("t6_mem_addr", 32'(mem_addr), 32'h0000);
        chk("t6_mem_wdata", 32'(mem_wdata), 32'h0007);
        step();
        cpu_we = 0;
        @(negedge clk);
        chk("t6_no_rvalid", 32'(cpu_rvalid), 32'd0);
        step(); drive_idle();
        @(negedge clk);
        chk("t6_readback", 32'(cpu_rdata), 32'h0007);
        $display("t6 cpu write/readback addr=0000 done");

        step(); step();
        chk("q_cpu_empty", 32'(cpu_q.size()), 32'd0);
        chk("q_dbg_empty", 32'(dbg_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
